// File: rtl/instr_ctrl.sv
// Instruction sequencer: latches a 16-bit instruction and walks a Moore FSM that
// drives register-file selects/write enable and datapath load/select strobes.
module instr_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    typedef enum logic [2:0] {
        StWait,
        StDecode,
        StWimm,
        StGetA,
        StGetB,
        StExec,
        StWreg
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;

    logic [2:0]  w_opcode;
    logic [1:0]  w_op;
    logic [2:0]  w_rn;
    logic [2:0]  w_rd;
    logic [2:0]  w_rm;
    logic        w_is_mov;
    logic        w_is_alu;
    logic        w_mov_imm;
    logic        w_mov_reg;
    logic        w_mvn;
    logic        w_cmp;
    logic        w_two_src;

    assign w_opcode  = r_ir[15:13];
    assign w_op      = r_ir[12:11];
    assign w_rn      = r_ir[10:8];
    assign w_rd      = r_ir[7:5];
    assign w_rm      = r_ir[2:0];

    assign w_is_mov  = (w_opcode == 3'b110);
    assign w_is_alu  = (w_opcode == 3'b101);
    assign w_mov_imm = w_is_mov && (w_op == 2'b10);
    assign w_mov_reg = w_is_mov && (w_op == 2'b00);
    assign w_mvn     = w_is_alu && (w_op == 2'b11);
    assign w_cmp     = w_is_alu && (w_op == 2'b01);
    // ADD, CMP and AND read both Rn and Rm; MVN only reads Rm
    assign w_two_src = w_is_alu && (w_op != 2'b11);

    assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};
    assign sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};
    assign ALUop  = w_is_mov ? 2'b00 : w_op;
    assign shift  = w_mov_imm ? 2'b00 : r_ir[4:3];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StWait;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_next;
            if ((r_state == StWait) && load) begin
                r_ir <= in;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            StWait: begin
                if (s) w_next = StDecode;
            end
            StDecode: begin
                if (w_mov_imm)                 w_next = StWimm;
                else if (w_mov_reg || w_mvn)   w_next = StGetB;
                else if (w_two_src)            w_next = StGetA;
                else                           w_next = StWait;
            end
            StWimm:  w_next = StWait;
            StGetA:  w_next = StGetB;
            StGetB:  w_next = StExec;
            StExec:  w_next = w_cmp ? StWait : StWreg;
            StWreg:  w_next = StWait;
            default: w_next = StWait;
        endcase
    end

    always_comb begin
        w        = 1'b0;
        readnum  = 3'b000;
        writenum = 3'b000;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 2'b00;
        unique case (r_state)
            StWait: w = 1'b1;
            StDecode: ;
            StWimm: begin
                writenum = w_rn;
                write    = 1'b1;
                vsel     = 2'b01;
            end
            StGetA: begin
                readnum = w_rn;
                loada   = 1'b1;
            end
            StGetB: begin
                readnum = w_rm;
                loadb   = 1'b1;
            end
            StExec: begin
                asel = w_mov_reg || w_mvn;
                if (w_cmp) loads = 1'b1;
                else       loadc = 1'b1;
            end
            StWreg: begin
                writenum = w_rd;
                write    = 1'b1;
            end
            default: ;
        endcase
        // Reset must suppress any in-flight write or load before the state clears
        if (reset) begin
            write = 1'b0;
            loada = 1'b0;
            loadb = 1'b0;
            loadc = 1'b0;
            loads = 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_ctrl.sv
// Directed, table-driven bench for instr_ctrl plus hand-written reset-abort sequences.
module tb_instr_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  ALUop;
    logic [1:0]  shift;
    logic [15:0] sximm8;
    logic [15:0] sximm5;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .load     (load),
        .s        (s),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .ALUop    (ALUop),
        .shift    (shift),
        .sximm8   (sximm8),
        .sximm5   (sximm5)
    );

    // Packed view: {w, readnum, writenum, write, loada, loadb, loadc, loads,
    //               asel, bsel, vsel, ALUop, shift, sximm8, sximm5}
    typedef struct {
        logic        rst;
        logic        ld;
        logic [15:0] din;
        logic        st;
        logic [51:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [51:0] outs_now();
        return {w, readnum, writenum, write, loada, loadb, loadc, loads,
                asel, bsel, vsel, ALUop, shift, sximm8, sximm5};
    endfunction

    task automatic add(input logic rst, input logic ld, input logic [15:0] din, input logic st,
                       input logic ew, input logic [2:0] ern, input logic [2:0] ewn,
                       input logic ewr, input logic ela, input logic elb, input logic elc,
                       input logic els, input logic eas, input logic ebs, input logic [1:0] evs,
                       input logic [1:0] ealu, input logic [1:0] esh,
                       input logic [15:0] ex8, input logic [15:0] ex5);
        vec_t v;
        v.rst = rst;
        v.ld  = ld;
        v.din = din;
        v.st  = st;
        v.exp = {ew, ern, ewn, ewr, ela, elb, elc, els, eas, ebs, evs, ealu, esh, ex8, ex5};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [51:0] exp);
        logic [51:0] act;
        act = outs_now();
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic ld, input logic [15:0] din, input logic st);
        reset = rst;
        load  = ld;
        in    = din;
        s     = st;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        in    = 16'h0000;
        s     = 1'b0;

        //  rst ld  din      s |  w rn wn wr la lb lc ls as bs vs alu sh  sximm8   sximm5
        add(1, 0, 16'h0000, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        // MOV R1,#-2
        add(0, 1, 16'hD1FE, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFE, 16'hFFFE);
        add(0, 0, 16'h0000, 0,   0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'hFFFE, 16'hFFFE);
        add(0, 0, 16'h0000, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFE, 16'hFFFE);
        // ADD R2,R1,R0,LSL#1 with an ignored load of 0xD007 during GETB
        add(0, 1, 16'hA148, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0048, 16'h0008);
        add(0, 0, 16'h0000, 0,   0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0048, 16'h0008);
        add(0, 1, 16'hD007, 0,   0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0048, 16'h0008);
        add(0, 0, 16'h0000, 0,   0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 16'h0048, 16'h0008);
        add(0, 0, 16'h0000, 0,   0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0048, 16'h0008);
        add(0, 0, 16'h0000, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0048, 16'h0008);
        // CMP R0,R1
        add(0, 1, 16'hA801, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0001, 16'h0001);
        add(0, 0, 16'h0000, 0,   0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0001, 16'h0001);
        add(0, 0, 16'h0000, 0,   0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 16'h0001, 16'h0001);
        add(0, 0, 16'h0000, 0,   0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 16'h0001, 16'h0001);
        add(0, 0, 16'h0000, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0001, 16'h0001);
        // MVN R3,R0
        add(0, 1, 16'hB860, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 16'h0060, 16'h0000);
        add(0, 0, 16'h0000, 0,   0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3, 0, 16'h0060, 16'h0000);
        add(0, 0, 16'h0000, 0,   0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 3, 0, 16'h0060, 16'h0000);
        add(0, 0, 16'h0000, 0,   0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 16'h0060, 16'h0000);
        add(0, 0, 16'h0000, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 16'h0060, 16'h0000);
        // Unsupported opcode: one DECODE cycle, no strobes
        add(0, 1, 16'hE000, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        // MOV R5,R1,LSL#1 with s held high across two back-to-back runs
        add(0, 1, 16'hC0A9, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFA9, 16'h0009);
        add(0, 0, 16'h0000, 1,   0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 16'hFFA9, 16'h0009);
        add(0, 0, 16'h0000, 1,   0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 16'hFFA9, 16'h0009);
        add(0, 0, 16'h0000, 1,   0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFA9, 16'h0009);
        add(0, 0, 16'h0000, 1,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFA9, 16'h0009);
        add(0, 0, 16'h0000, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFA9, 16'h0009);
        add(0, 0, 16'h0000, 0,   0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 16'hFFA9, 16'h0009);
        add(0, 0, 16'h0000, 0,   0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 16'hFFA9, 16'h0009);
        add(0, 0, 16'h0000, 0,   0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFA9, 16'h0009);
        add(0, 0, 16'h0000, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFA9, 16'h0009);
        // Load in WAIT without start just updates IR
        add(0, 1, 16'hD1FE, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFE, 16'hFFFE);

        @(negedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].ld, vecs[i].din, vecs[i].st);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset during ADD's GETB: strobes drop combinationally, IR clears
        step(0, 1, 16'hA148, 1);
        step(0, 0, 16'h0000, 0);
        step(0, 0, 16'h0000, 0);
        check_bit("rst_pre_getb_loadb", loadb, 1'b1);
        reset = 1'b1;
        #1;
        check_bit("rst_getb_loadb", loadb, 1'b0);
        check_bit("rst_getb_write", write, 1'b0);
        step(1, 0, 16'h0000, 0);
        step(0, 0, 16'h0000, 0);
        check("rst_getb_after",
              {1'b1, 3'd0, 3'd0, 1'b0, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000});

        // Reset during WREG: the pending write is suppressed and never happens
        step(0, 1, 16'hB860, 1);
        step(0, 0, 16'h0000, 0);
        step(0, 0, 16'h0000, 0);
        step(0, 0, 16'h0000, 0);
        check_bit("rst_pre_wreg_write", write, 1'b1);
        reset = 1'b1;
        #1;
        check_bit("rst_wreg_write", write, 1'b0);
        step(1, 0, 16'h0000, 0);
        check_bit("rst_wreg_w", w, 1'b1);
        step(0, 0, 16'h0000, 0);
        check_bit("rst_wreg_no_write", write, 1'b0);
        check_bit("rst_wreg_idle", w, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
